// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for the shared 8:1 haptic channel mux: grant, settle, then
// offer one sample per grant on a valid/ready handshake.
module mux8_rr_scheduler #(
    parameter int unsigned SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req,
    input  logic [SETTLE_W-1:0] settle_cyc,
    output logic [2:0]          sel,
    output logic [7:0]          grant,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                done,
    output logic                abort,
    output logic [2:0]          done_ch,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          ptr, ptr_nxt;
    logic [SETTLE_W-1:0] cnt, cnt_nxt;
    logic [2:0]          sel_nxt, done_ch_nxt;
    logic [7:0]          grant_nxt;
    logic                smp_valid_nxt, done_nxt, abort_nxt, busy_nxt;
    logic [2:0]          win;
    logic                win_found;

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!win_found && req[3'(32'(ptr) + i)]) begin
                win       = 3'(32'(ptr) + i);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        sel_nxt       = sel;
        grant_nxt     = grant;
        smp_valid_nxt = smp_valid;
        done_nxt      = 1'b0;
        abort_nxt     = 1'b0;
        done_ch_nxt   = done_ch;

        unique case (state)
            IDLE: begin
                grant_nxt     = '0;
                smp_valid_nxt = 1'b0;
                if (win_found) begin
                    state_nxt = SETTLE;
                    sel_nxt   = win;
                    grant_nxt = 8'b1 << win;
                    cnt_nxt   = settle_cyc;
                end
            end
            SETTLE: begin
                if (!req[sel]) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    smp_valid_nxt = 1'b0;
                    abort_nxt     = 1'b1;
                    done_ch_nxt   = sel;
                    ptr_nxt       = sel + 3'd1;
                end else if (cnt == '0) begin
                    state_nxt     = SAMPLE;
                    smp_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                // Handshake takes priority over a request drop in the same cycle.
                if (smp_valid && smp_ready) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    smp_valid_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    done_ch_nxt   = sel;
                    ptr_nxt       = sel + 3'd1;
                end else if (!req[sel]) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    smp_valid_nxt = 1'b0;
                    abort_nxt     = 1'b1;
                    done_ch_nxt   = sel;
                    ptr_nxt       = sel + 3'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                grant_nxt     = '0;
                smp_valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            grant     <= '0;
            smp_valid <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            done_ch   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            grant     <= grant_nxt;
            smp_valid <= smp_valid_nxt;
            done      <= done_nxt;
            abort     <= abort_nxt;
            done_ch   <= done_ch_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [3:0] settle_cyc;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       smp_valid;
    logic       smp_ready;
    logic       done;
    logic       abort;
    logic [2:0] done_ch;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mux8_rr_scheduler #(.SETTLE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .settle_cyc(settle_cyc),
        .sel       (sel),
        .grant     (grant),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .done      (done),
        .abort     (abort),
        .done_ch   (done_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the mux, how long until the sample is offered.
    int owner = -1;
    int m_ptr = 0;
    int m_sel = 0;
    int m_wait = 0;
    bit m_valid = 0;
    bit m_done = 0;
    bit m_abort = 0;
    int m_dch = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            owner = -1; m_ptr = 0; m_sel = 0; m_wait = 0;
            m_valid = 0; m_done = 0; m_abort = 0; m_dch = 0;
        end else begin
            m_done = 0;
            m_abort = 0;
            if (owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (owner < 0 && req[(m_ptr + k) % 8]) owner = (m_ptr + k) % 8;
                end
                if (owner >= 0) begin
                    m_sel = owner;
                    m_wait = int'(settle_cyc);
                    m_valid = 0;
                end
            end else if (m_valid && smp_ready) begin
                m_done = 1; m_dch = owner; m_ptr = (owner + 1) % 8;
                owner = -1; m_valid = 0;
            end else if (!req[owner]) begin
                m_abort = 1; m_dch = owner; m_ptr = (owner + 1) % 8;
                owner = -1; m_valid = 0;
            end else if (!m_valid) begin
                if (m_wait == 0) m_valid = 1;
                else m_wait--;
            end
        end
        chk("m_sel", sel, m_sel);
        chk("m_grant", grant, (owner < 0) ? 0 : (1 << owner));
        chk("m_smp_valid", smp_valid, m_valid);
        chk("m_busy", busy, owner >= 0);
        chk("m_done", done, m_done);
        chk("m_abort", abort, m_abort);
        if (m_done || m_abort || rst) chk("m_done_ch", done_ch, m_dch);
    end

    // Advances until a done/abort pulse is visible; returns the cycles taken.
    task automatic wait_pulse(input string tag, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done || abort) begin
                cyc = c;
                return;
            end
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1; req = '0; settle_cyc = '0; smp_ready = 1'b0;

        // Reset held two clocks
        repeat (2) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_grant", grant, 0);
        chk("rst_valid", smp_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single request on ch3 with settle 3
        @(negedge clk);
        req = 8'h08; settle_cyc = 4'd3; smp_ready = 1'b1;
        @(negedge clk);
        chk("t2_grant", grant, 8'h08);
        chk("t2_sel", sel, 3);
        repeat (3) @(negedge clk);
        chk("t2_valid_early", smp_valid, 0);
        @(negedge clk);
        chk("t2_valid", smp_valid, 1);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_done_ch", done_ch, 3);
        chk("t2_grant_off", grant, 0);
        req = 8'h18;
        @(negedge clk);
        chk("t2_ptr4", grant, 8'h10);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // All channels requesting, settle 0: strict rotation with wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 8'hFF; settle_cyc = 4'd0; smp_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_pulse("t3", cyc);
            chk("t3_order", done_ch, k % 8);
            chk("t3_gap", cyc, 3);
        end

        // ptr=1 now, only ch7 and ch0 request
        req = 8'h81;
        wait_pulse("t4a", cyc);
        chk("t4_first", done_ch, 7);
        wait_pulse("t4b", cyc);
        chk("t4_second", done_ch, 0);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Stalled sampler, then request drop
        req = 8'h04; settle_cyc = 4'd2; smp_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = smp_valid;
        end
        chk("t5_valid_seen", seen, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", smp_valid, 1);
            chk("t5_hold_sel", sel, 2);
        end
        req = 8'h00;
        @(negedge clk);
        chk("t5_abort", abort, 1);
        chk("t5_done", done, 0);
        chk("t5_done_ch", done_ch, 2);
        chk("t5_grant", grant, 0);
        repeat (2) @(negedge clk);

        // Reset during settle of ch5
        req = 8'h20; settle_cyc = 4'd10; smp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (grant == 8'h20);
        end
        chk("t6_grant_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_grant", grant, 0);
        chk("t6_sel", sel, 0);
        chk("t6_done", done, 0);
        chk("t6_abort", abort, 0);
        chk("t6_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_regrant", grant, 8'h20);
        chk("t6_resel", sel, 5);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) req = 8'($urandom);
            if ($urandom_range(3) == 0) settle_cyc = 4'($urandom_range(15));
            smp_ready = ($urandom_range(2) != 0);
            rst = ($urandom_range(199) == 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
